// File: rtl/row_accumulator.sv
// Row accumulator: per-channel product drain that sums each CSR row into
// one signed dot product and presents it on a valid/read handshake.
//
// Ports (channel i occupies slice i of every packed bus):
//   clk, rst              clock, synchronous active-high reset
//   mult / _empty / _read FWFT product FIFO, 2*val_bits signed per channel
//   len  / _empty / _read FWFT row-length FIFO, len_bits unsigned per channel
//   res / res_valid       row sum (acc_bits signed) and its valid flag
//   res_read              consumer accepts res for that channel
module row_accumulator #(
  parameter int channel_num = 4,
  parameter int val_bits    = 16,
  parameter int len_bits    = 8,
  parameter int acc_bits    = 40
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [val_bits*2*channel_num-1:0] mult,
  input  logic [channel_num-1:0]          mult_fifo_empty,
  output logic [channel_num-1:0]          mult_fifo_read,
  input  logic [len_bits*channel_num-1:0] len,
  input  logic [channel_num-1:0]          len_fifo_empty,
  output logic [channel_num-1:0]          len_fifo_read,
  output logic [acc_bits*channel_num-1:0] res,
  output logic [channel_num-1:0]          res_valid,
  input  logic [channel_num-1:0]          res_read
);

  localparam int PW = 2 * val_bits;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  for (genvar g = 0; g < channel_num; g++) begin : g_ch
    state_t                r_state;
    state_t                w_next;
    logic [acc_bits-1:0]   r_acc;
    logic [len_bits-1:0]   r_cnt;
    logic                  w_len_rd;
    logic                  w_mult_rd;
    logic signed [PW-1:0]  w_prod;
    logic [acc_bits-1:0]   w_ext;
    logic [len_bits-1:0]   w_len;

    assign w_prod = mult[g*PW +: PW];
    assign w_len  = len[g*len_bits +: len_bits];
    // signed size cast replicates the product's sign bit
    assign w_ext  = acc_bits'(w_prod);

    always_comb begin
      w_next    = r_state;
      w_len_rd  = 1'b0;
      w_mult_rd = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!len_fifo_empty[g]) begin
            w_len_rd = 1'b1;
            w_next   = (w_len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (!mult_fifo_empty[g]) begin
            w_mult_rd = 1'b1;
            if (r_cnt == len_bits'(1)) w_next = S_DONE;
          end
        end
        S_DONE: begin
          if (res_read[g]) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
      // a pop during reset would drop an entry the FSM never sees
      if (rst) begin
        w_len_rd  = 1'b0;
        w_mult_rd = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        r_state <= w_next;
        if (w_len_rd) begin
          r_acc <= '0;
          r_cnt <= w_len;
        end else if (w_mult_rd) begin
          r_acc <= r_acc + w_ext;
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end

    assign mult_fifo_read[g]            = w_mult_rd;
    assign len_fifo_read[g]             = w_len_rd;
    assign res_valid[g]                 = (r_state == S_DONE);
    assign res[g*acc_bits +: acc_bits]  = r_acc;
  end

endmodule

// File: tb/tb_row_accumulator.sv
// Bench for row_accumulator: queue-based FIFO/row-sum model, directed
// rows, backpressure, reset mid-row, a 32-bit wrap instance, random rows.
module tb_row_accumulator;
  localparam int CN = 4;
  localparam int VB = 16;
  localparam int LB = 8;
  localparam int AB = 40;
  localparam int PW = 2 * VB;

  typedef logic signed [PW-1:0] prod_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [PW*CN-1:0]  mult;
  logic [CN-1:0]     mult_fifo_empty;
  logic [CN-1:0]     mult_fifo_read;
  logic [LB*CN-1:0]  len;
  logic [CN-1:0]     len_fifo_empty;
  logic [CN-1:0]     len_fifo_read;
  logic [AB*CN-1:0]  res;
  logic [CN-1:0]     res_valid;
  logic [CN-1:0]     res_read;

  row_accumulator #(
    .channel_num(CN), .val_bits(VB), .len_bits(LB), .acc_bits(AB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .mult(mult), .mult_fifo_empty(mult_fifo_empty),
    .mult_fifo_read(mult_fifo_read),
    .len(len), .len_fifo_empty(len_fifo_empty),
    .len_fifo_read(len_fifo_read),
    .res(res), .res_valid(res_valid), .res_read(res_read)
  );

  logic [31:0] w_mult;
  logic        w_me, w_mr, w_le, w_lr, w_rv, w_rr;
  logic [7:0]  w_len;
  logic [31:0] w_res;

  row_accumulator #(
    .channel_num(1), .val_bits(16), .len_bits(8), .acc_bits(32)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .mult(w_mult), .mult_fifo_empty(w_me), .mult_fifo_read(w_mr),
    .len(w_len), .len_fifo_empty(w_le), .len_fifo_read(w_lr),
    .res(w_res), .res_valid(w_rv), .res_read(w_rr)
  );

  int           lq[CN][$];
  prod_t        pq[CN][$];
  logic [AB-1:0] eq[CN][$];
  int           mmode[CN];
  int           lmode[CN];
  int           rmode[CN];
  int           lpop[CN];
  bit           pv[CN];
  bit           prr[CN];
  logic [AB-1:0] pres[CN];
  bit           pm[CN];
  bit           pl[CN];
  bit           prst;
  int           cyc;
  int           checks;
  int           errors;
  bit           wlr_s;
  bit           w_done;
  int           wm_cnt;
  logic [31:0]  w_got;
  prod_t        none[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit stall(input int m);
    if (m == 1) return cyc[0];
    if (m == 2) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic drive();
    for (int c = 0; c < CN; c++) begin
      mult_fifo_empty[c] = (pq[c].size() == 0) || stall(mmode[c]);
      mult[c*PW +: PW]   = (pq[c].size() != 0) ? pq[c][0] : '0;
      len_fifo_empty[c]  = (lq[c].size() == 0) || stall(lmode[c]);
      len[c*LB +: LB]    = (lq[c].size() != 0) ? LB'(lq[c][0]) : '0;
      if (rmode[c] == 2) res_read[c] = ($urandom_range(0, 2) != 0);
      else res_read[c] = (rmode[c] == 1);
    end
  endtask

  task automatic push_row(input int c, input prod_t p[$], input bit keep);
    longint s = 0;
    foreach (p[i]) begin
      pq[c].push_back(p[i]);
      s += longint'(p[i]);
    end
    lq[c].push_back(p.size());
    if (keep) eq[c].push_back(s[AB-1:0]);
    drive();
  endtask

  task automatic cycle();
    logic [AB-1:0] r;
    @(negedge clk);
    for (int c = 0; c < CN; c++) begin
      r = res[c*AB +: AB];
      chk("mrd_empty", 64'(mult_fifo_read[c] & mult_fifo_empty[c]), 0);
      chk("lrd_empty", 64'(len_fifo_read[c] & len_fifo_empty[c]), 0);
      if (rst || res_valid[c])
        chk("rd_quiet", {mult_fifo_read[c], len_fifo_read[c]}, 0);
      if (pv[c] && !prr[c] && !prst) begin
        chk("hold_v", 64'(res_valid[c]), 1);
        chk("hold_r", r, pres[c]);
      end
      if (res_valid[c] && !pv[c])
        chk("latency", 64'(cyc - lpop[c]), 1);
      if (res_valid[c] && res_read[c]) begin
        if (eq[c].size() == 0) chk("extra_res", 1, 0);
        else chk("res", r, eq[c].pop_front());
      end
      if (len_fifo_read[c] || mult_fifo_read[c]) lpop[c] = cyc;
      pm[c]   = mult_fifo_read[c];
      pl[c]   = len_fifo_read[c];
      pv[c]   = res_valid[c];
      prr[c]  = res_read[c];
      pres[c] = r;
    end
    prst  = rst;
    wlr_s = w_lr;
    if (w_mr) wm_cnt++;
    if (w_rv && w_rr && !w_done) begin
      w_got  = w_res;
      w_done = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < CN; c++) begin
      if (pm[c]) void'(pq[c].pop_front());
      if (pl[c]) void'(lq[c].pop_front());
    end
    if (wlr_s) w_le = 1'b1;
    if (w_done) w_me = 1'b1;
    drive();
  endtask

  function automatic bit busy();
    for (int c = 0; c < CN; c++)
      if (lq[c].size() || pq[c].size() || eq[c].size()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int lim);
    int n = 0;
    while (busy() && n < lim) begin
      cycle();
      n++;
    end
    chk("drain", 64'(busy()), 0);
    repeat (2) cycle();
  endtask

  initial begin
    logic signed [VB-1:0] a, b;
    prod_t rowq[$];
    checks = 0;
    errors = 0;
    cyc    = 0;
    prst   = 1'b1;
    w_done = 1'b0;
    wm_cnt = 0;
    w_got  = '0;
    w_mult = 32'h7FFF0001;
    w_me   = 1'b1;
    w_le   = 1'b1;
    w_len  = 8'd2;
    w_rr   = 1'b1;
    for (int c = 0; c < CN; c++) begin
      mmode[c] = 0;
      lmode[c] = 0;
      rmode[c] = 1;
      lpop[c]  = 0;
      pv[c]    = 1'b0;
      prr[c]   = 1'b0;
      pres[c]  = '0;
    end
    rst = 1'b1;
    drive();
    repeat (2) cycle();
    @(negedge clk);
    for (int c = 0; c < CN; c++) begin
      chk("rst_valid", 64'(res_valid[c]), 0);
      chk("rst_res", res[c*AB +: AB], 0);
      chk("rst_reads", {mult_fifo_read[c], len_fifo_read[c]}, 0);
    end
    rst = 1'b0;

    // 32-bit wrap: 0x7FFF0001 + 0x7FFF0001
    w_le = 1'b0;
    w_me = 1'b0;
    for (int i = 0; i < 20 && !w_done; i++) cycle();
    chk("wrap_done", 64'(w_done), 1);
    chk("wrap_res", w_got, 32'hFFFE0002);
    chk("wrap_pops", 64'(wm_cnt), 2);

    // ch0 3-term row, ch1 empty row, ch2 with toggling empty flag
    mmode[2] = 1;
    push_row(0, '{5, -2, 7}, 1);
    push_row(1, none, 1);
    push_row(2, '{1000, 1000, 1000, 1000}, 1);
    wait_drain(100);
    mmode[2] = 0;

    // ch3 held in DONE while ch0 finishes two rows
    rmode[3] = 0;
    push_row(3, '{8}, 1);
    push_row(3, '{-3, 2}, 1);
    push_row(0, '{3, 4}, 1);
    push_row(0, '{-9}, 1);
    repeat (10) cycle();
    chk("bp_valid", 64'(res_valid[3]), 1);
    chk("bp_res", res[3*AB +: AB], 8);
    chk("bp_lenq", 64'(lq[3].size()), 1);
    chk("bp_prodq", 64'(pq[3].size()), 2);
    chk("bp_ch0", 64'(eq[0].size()), 0);
    rmode[3] = 1;
    wait_drain(100);

    // reset after two of five pops; upstream is flushed alongside
    push_row(0, '{1, 2, 3, 4, 5}, 0);
    repeat (3) cycle();
    chk("mid_pops", 64'(pq[0].size()), 3);
    rst = 1'b1;
    drive();
    cycle();
    rst = 1'b0;
    lq[0].delete();
    pq[0].delete();
    drive();
    chk("mid_valid", 64'(res_valid[0]), 0);
    chk("mid_acc", res[AB-1:0], 0);
    push_row(0, '{6}, 1);
    wait_drain(100);

    // random rows with random stalls and backpressure
    for (int c = 0; c < CN; c++) begin
      mmode[c] = 2;
      lmode[c] = 2;
      rmode[c] = 2;
    end
    for (int r = 0; r < 80; r++) begin
      rowq.delete();
      for (int k = 0; k < int'($urandom_range(0, 7)); k++) begin
        a = VB'($urandom);
        b = VB'($urandom);
        rowq.push_back(prod_t'(PW'(a)) * prod_t'(PW'(b)));
      end
      push_row(int'($urandom_range(0, CN - 1)), rowq, 1);
    end
    wait_drain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_accumulator.md
Name: row_accumulator

Overview:
- Consumer side of the per-channel product FIFOs; drains the signed products the multiplier channels write.
- Sums them into per-row dot products using a per-channel row-length FIFO (CSR nonzeros-per-row).
- Presents one result per row on a valid/read handshake toward the output writer.
- One independent accumulator FSM per channel; all channels share clk/rst.

Parameters:
channel_num, 4, number of independent channels
val_bits, 16, width of one matrix/vector value; products are 2*val_bits signed
len_bits, 8, width of a row-length entry (unsigned, 0..2^len_bits-1)
acc_bits, 40, signed accumulator/result width; must be >= 2*val_bits

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mult  input  val_bits*2*channel_num  packed products, channel i at [i*2*val_bits +: 2*val_bits], first-word-fall-through
mult_fifo_empty  input  channel_num  product FIFO empty per channel
mult_fifo_read  output  channel_num  pop product FIFO per channel
len  input  len_bits*channel_num  packed row lengths, channel i at [i*len_bits +: len_bits], FWFT
len_fifo_empty  input  channel_num  row-length FIFO empty per channel
len_fifo_read  output  channel_num  pop row-length FIFO per channel
res  output  acc_bits*channel_num  packed row sums, channel i at [i*acc_bits +: acc_bits]
res_valid  output  channel_num  row sum valid per channel
res_read  input  channel_num  consumer accepts res for that channel

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- FIFO inputs are FWFT: data is valid whenever the matching empty flag is low. A read pulse pops the entry at that edge.
- Reads are never asserted on an empty FIFO, and never while rst=1.
- Per-channel FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- Reset values: acc=0, count=0, res_valid=0, res=0, mult_fifo_read=0, len_fifo_read=0.
- IDLE:
  - len_fifo_read = !len_fifo_empty.
  - On the pop: acc<=0, count<=len.
  - If len==0, next state is DONE (emits a 0 row sum). Otherwise next state is ACC.
- ACC:
  - mult_fifo_read = !mult_fifo_empty (combinational, same cycle).
  - On each pop: acc <= acc + sign_extend(product, acc_bits); count <= count-1.
  - The pop with count==1 moves the FSM to DONE.
  - A stalled cycle (FIFO empty) holds acc and count.
- DONE:
  - res_valid=1 and res=acc, both held stable until res_read=1.
  - The res_read=1 cycle returns the FSM to IDLE and drops res_valid at the next edge.
  - No FIFO reads occur in DONE.
- res_read while res_valid=0 is ignored.
- Arithmetic: two's complement. Overflow wraps modulo 2^acc_bits; no saturation and no flag.
- Throughput: one product per cycle per channel in ACC. Per-row overhead is one IDLE cycle plus at least one DONE cycle.
- Latency: the last product pop at edge t gives res_valid=1 after edge t; a zero-length row gives res_valid one cycle after the len pop.
- Channels are fully independent; a stall or backpressure on one channel never affects another.
- Reset mid-row:
  - Consumed products are lost; FSM returns to IDLE with acc=0.
  - res_valid drops at that edge.
  - Upstream FIFOs are not flushed by this block.
- Simultaneous events: a len entry arriving while in ACC or DONE is not read until IDLE.

Test Plan:
- Ch0 len=3, products 5, -2, 7 back-to-back, res_read tied 1 -> one res_valid pulse, res=10, asserted the cycle after the third pop; 5 cycles from len pop to back in IDLE.
- Ch1 len=0 -> no mult read, res_valid=1 with res=0 one cycle after the len pop.
- Ch2 len=4, products 1000,1000,1000,1000 with mult_fifo_empty toggled every other cycle -> mult_fifo_read only when non-empty, res=4000.
- Signed/wrap: val_bits=16, acc_bits=32, len=2, products 0x7FFF0001 twice -> res=0xFFFE0002 (wrapped).
- Backpressure: ch3 res_read=0 for 10 cycles while ch3 has a queued len and products -> res stable, no further pops on ch3. Meanwhile ch0 completes two rows (len=2: 3,4 and len=1: -9 -> res 7 then -9).
- Reset mid-row: len=5, rst after 2 pops -> next-cycle res_valid=0, reads 0. After release, a fresh len=1, product 6 -> res=6.
